// File: rtl/codein_if.sv
// codein_if: source-side bundle between the DMA source port, the descriptor
// control word and the two coder input lanes of codein.
//   dc          descriptor control (dc[5] encode, dc[6] decode)
//   m_src*      show-ahead 64-bit source word, empty flag, last flag, lane count
//   en_in_*     16-bit lane stream to the encoder (ready in, data/valid/last out)
//   de_in_*     16-bit lane stream to the decoder (ready in, data/valid/last out)
// master = environment side (source and coders), slave = codein.
interface codein_if;
    logic [23:0] dc;
    logic [63:0] m_src;
    logic        m_src_empty;
    logic        m_src_last;
    logic [1:0]  m_src_lanes;
    logic        en_in_ready;
    logic        de_in_ready;
    logic [15:0] en_in_data;
    logic [15:0] de_in_data;
    logic        en_in_valid;
    logic        de_in_valid;
    logic        en_in_last;
    logic        de_in_last;

    modport master (
        output dc, m_src, m_src_empty, m_src_last, m_src_lanes,
        output en_in_ready, de_in_ready,
        input  en_in_data, de_in_data, en_in_valid, de_in_valid,
        input  en_in_last, de_in_last
    );

    modport slave (
        input  dc, m_src, m_src_empty, m_src_last, m_src_lanes,
        input  en_in_ready, de_in_ready,
        output en_in_data, de_in_data, en_in_valid, de_in_valid,
        output en_in_last, de_in_last
    );
endinterface

// File: rtl/codein.sv
// codein: 64-to-16 unpacker feeding the encoder or decoder.
// Pops show-ahead 64-bit source words and presents them as 16-bit lanes,
// lane 0 = bits [15:0] first, honouring per-lane backpressure from the
// selected coder and flagging the final lane of the job.
// Ports:
//   wb_clk_i    system clock, rising edge
//   wb_rst_ni   asynchronous active-low reset
//   bus         codein_if.slave: dc, m_src*, en_in_*, de_in_*
//   m_src_getn  active-low pop strobe (combinational), floats while inactive
module codein (
    input  logic     wb_clk_i,
    input  logic     wb_rst_ni,
    codein_if.slave  bus,
    // Kept off the interface because it floats when the block is idle.
    output wire      m_src_getn
);

    localparam int unsigned WORD_W = 64;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_buf;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_lim;
    logic                r_last;
    logic [LANE_W-1:0]   r_data;
    logic                r_en_valid;
    logic                r_de_valid;
    logic                r_lane_last;

    state_t              w_state_nxt;
    logic [WORD_W-1:0]   w_buf_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_lim_nxt;
    logic                w_last_nxt;
    logic                w_valid_nxt;
    logic                w_load;
    logic [LANE_W-1:0]   w_data_nxt;
    logic                w_lane_last_nxt;

    logic                w_active;
    logic                w_sel_enc;
    logic                w_ready;
    logic                w_at_lim;
    logic                w_unused_dc;

    // Job qualification and coder selection; encode wins if both are set.
    assign w_active    = bus.dc[5] | bus.dc[6];
    assign w_sel_enc   = bus.dc[5];
    assign w_ready     = w_sel_enc ? bus.en_in_ready : bus.de_in_ready;
    assign w_at_lim    = (r_cnt == r_lim);
    assign w_unused_dc = ^{bus.dc[23:7], bus.dc[4:0]};

    // Next-state, pop decision and next lane contents.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_lim_nxt   = r_lim;
        w_last_nxt  = r_last;
        w_valid_nxt = (r_state == S_SHIFT);
        w_load      = 1'b0;

        if (!w_active) begin
            // Abort / job end: restart cleanly, keep buf contents.
            w_state_nxt = S_FILL;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                S_FILL: begin
                    w_valid_nxt = 1'b0;
                    if (!bus.m_src_empty) begin
                        w_load = 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_ready) begin
                        if (!w_at_lim) begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end else if (r_last) begin
                            w_state_nxt = S_DONE;
                            w_valid_nxt = 1'b0;
                        end else if (!bus.m_src_empty) begin
                            // Back-to-back reload, no bubble between words.
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = S_FILL;
                            w_valid_nxt = 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    w_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = S_FILL;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end

        if (w_load) begin
            w_state_nxt = S_SHIFT;
            w_buf_nxt   = bus.m_src;
            w_cnt_nxt   = '0;
            w_last_nxt  = bus.m_src_last;
            w_lim_nxt   = bus.m_src_last ? bus.m_src_lanes : CNT_W'(3);
            w_valid_nxt = 1'b1;
        end

        w_data_nxt      = w_buf_nxt[{w_cnt_nxt, 4'b0000} +: LANE_W];
        w_lane_last_nxt = w_valid_nxt & w_last_nxt & (w_cnt_nxt == w_lim_nxt);
    end

    // State and registered outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= S_FILL;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_lim       <= '0;
            r_last      <= 1'b0;
            r_data      <= '0;
            r_en_valid  <= 1'b0;
            r_de_valid  <= 1'b0;
            r_lane_last <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf       <= w_buf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lim       <= w_lim_nxt;
            r_last      <= w_last_nxt;
            r_data      <= w_data_nxt;
            r_en_valid  <= w_valid_nxt & w_sel_enc;
            r_de_valid  <= w_valid_nxt & ~w_sel_enc;
            r_lane_last <= w_lane_last_nxt;
        end
    end

    assign bus.en_in_data  = r_data;
    assign bus.de_in_data  = r_data;
    assign bus.en_in_valid = r_en_valid;
    assign bus.de_in_valid = r_de_valid;
    assign bus.en_in_last  = r_lane_last;
    assign bus.de_in_last  = r_lane_last;

    assign m_src_getn = w_active ? ~w_load : 1'bz;

endmodule

// File: tb/tb_codein.sv
module tb_codein;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    codein_if bus ();
    wire getn;

    codein dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .bus        (bus.slave),
        .m_src_getn (getn)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [1:0]  lanes;
    } word_t;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        word_end;
    } lane_t;

    word_t       src_q[$];
    lane_t       exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          pops = 0;
    int          pop_cyc[$];
    bit          pop_pending = 0;
    bit          pend_lat = 0;
    bit          stall_prev = 0;
    logic [15:0] stall_data;
    bit          force_empty = 0;
    bit          gap_mode = 0;
    int          ready_mode = 0;
    int          rpat = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_src();
        bus.m_src_empty = force_empty || (src_q.size() == 0);
        if (src_q.size() != 0) begin
            bus.m_src       = src_q[0].data;
            bus.m_src_last  = src_q[0].last;
            bus.m_src_lanes = src_q[0].lanes;
        end else begin
            bus.m_src       = 64'd0;
            bus.m_src_last  = 1'b0;
            bus.m_src_lanes = 2'd0;
        end
    endtask

    // Reference model: a word expands into its list of lanes, low lane first.
    task automatic push_word(input logic [63:0] d, input bit last, input logic [1:0] lanes);
        word_t w;
        lane_t e;
        int    n;
        w.data  = d;
        w.last  = last;
        w.lanes = lanes;
        src_q.push_back(w);
        n = last ? int'(lanes) : 3;
        for (int i = 0; i <= n; i++) begin
            e.data     = d[16*i +: 16];
            e.last     = last && (i == n);
            e.word_end = (i == n);
            exp_q.push_back(e);
        end
        drive_src();
    endtask

    task automatic step();
        logic r;
        @(posedge clk);
        #1;
        if (pop_pending) begin
            if (src_q.size() != 0) void'(src_q.pop_front());
            pop_pending = 0;
        end
        case (ready_mode)
            0: begin
                bus.en_in_ready = 1'b1;
                bus.de_in_ready = 1'b1;
            end
            1: begin
                r = ((rpat % 4) == 0) || ((rpat % 4) == 3);
                rpat++;
                bus.en_in_ready = r;
                bus.de_in_ready = r;
            end
            default: begin
                bus.en_in_ready = 1'($urandom_range(0, 1));
                bus.de_in_ready = 1'($urandom_range(0, 1));
            end
        endcase
        if (gap_mode) force_empty = ($urandom_range(0, 3) == 0);
        drive_src();
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            src_q.delete();
            drive_src();
        end
    endtask

    task automatic end_job();
        step();
        step();
        bus.dc = 24'h0;
        step();
        step();
    endtask

    // Monitor: pops expected lanes on every accepted transfer and checks pops.
    always @(negedge clk) begin : mon
        logic        act, sv, uv, rdy, lst, acc_end;
        logic [15:0] dat;
        lane_t       e;
        cyc++;
        if (rst_n === 1'b1) begin
            act = bus.dc[5] | bus.dc[6];
            sv  = bus.dc[5] ? bus.en_in_valid : bus.de_in_valid;
            uv  = bus.dc[5] ? bus.de_in_valid : bus.en_in_valid;
            rdy = bus.dc[5] ? bus.en_in_ready : bus.de_in_ready;
            dat = bus.dc[5] ? bus.en_in_data  : bus.de_in_data;
            lst = bus.dc[5] ? bus.en_in_last  : bus.de_in_last;
            if (act) begin
                acc_end = 1'b0;
                check("unselected_valid", 64'(uv), 64'd0);
                if (pend_lat) check("pop_to_lane0", 64'(sv), 64'd1);
                if (stall_prev) begin
                    check("hold_valid", 64'(sv), 64'd1);
                    check("hold_data", 64'(dat), 64'(stall_data));
                end
                if (sv && rdy) begin
                    if (exp_q.size() == 0) begin
                        check("extra_lane", 64'(dat), 64'hDEAD_0000_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        check("lane_data", 64'(dat), 64'(e.data));
                        check("lane_last", 64'(lst), 64'(e.last));
                        acc_end = e.word_end;
                    end
                end
                pend_lat = 0;
                if (getn === 1'b0) begin
                    check("pop_when_empty", 64'(bus.m_src_empty), 64'd0);
                    check("pop_mid_word", 64'(!sv || acc_end), 64'd1);
                    pop_pending = 1;
                    pend_lat    = 1;
                    pops++;
                    pop_cyc.push_back(cyc);
                end
                stall_prev = sv && !rdy;
                stall_data = dat;
            end else begin
                stall_prev = 0;
                pend_lat   = 0;
            end
        end else begin
            stall_prev = 0;
            pend_lat   = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, i0, n;
        rst_n           = 1'b0;
        bus.dc          = 24'h0;
        bus.en_in_ready = 1'b0;
        bus.de_in_ready = 1'b0;
        drive_src();
        repeat (2) @(negedge clk);
        check("rst_en_valid", 64'(bus.en_in_valid), 64'd0);
        check("rst_de_valid", 64'(bus.de_in_valid), 64'd0);
        check("rst_en_data",  64'(bus.en_in_data),  64'd0);
        check("rst_en_last",  64'(bus.en_in_last),  64'd0);
        check("rst_de_last",  64'(bus.de_in_last),  64'd0);
        bus.dc = 24'h20;
        #1;
        check("rst_getn_idle", 64'(getn), 64'd1);
        step();
        rst_n = 1'b1;

        // Encode, two words, ready held high.
        ready_mode = 0;
        p0 = pops;
        i0 = pop_cyc.size();
        push_word(64'h0004_0003_0002_0001, 1'b0, 2'd0);
        push_word(64'h0008_0007_0006_0005, 1'b1, 2'd3);
        wait_drain(40);
        step();
        step();
        check("enc_pop_count", 64'(pops - p0), 64'd2);
        if (pop_cyc.size() >= i0 + 2)
            check("enc_pop_gap", 64'(pop_cyc[i0+1] - pop_cyc[i0]), 64'd4);
        end_job();

        // Decode, partial final word, then no pops in DONE.
        bus.dc = 24'h40;
        push_word(64'hDDDD_CCCC_BBBB_AAAA, 1'b1, 2'd1);
        wait_drain(20);
        step();
        p0 = pops;
        src_q.push_back('{data: 64'h1111_2222_3333_4444, last: 1'b0, lanes: 2'd0});
        drive_src();
        repeat (6) step();
        check("done_no_pop", 64'(pops - p0), 64'd0);
        src_q.delete();
        drive_src();
        end_job();

        // Backpressure pattern 1,0,0,1.
        bus.dc     = 24'h20;
        ready_mode = 1;
        rpat       = 0;
        push_word({$urandom, $urandom}, 1'b0, 2'd0);
        push_word({$urandom, $urandom}, 1'b0, 2'd0);
        push_word({$urandom, $urandom}, 1'b1, 2'd3);
        wait_drain(100);
        end_job();

        // Source underrun between word 1 and word 2.
        ready_mode = 0;
        bus.dc     = 24'h20;
        push_word(64'hA004_A003_A002_A001, 1'b0, 2'd0);
        wait_drain(20);
        for (int i = 0; i < 5; i++) begin
            check("underrun_valid", 64'(bus.en_in_valid), 64'd0);
            step();
        end
        push_word(64'hB004_B003_B002_B001, 1'b1, 2'd2);
        wait_drain(20);
        end_job();

        // Both encode and decode set: encoder path only.
        ready_mode = 2;
        bus.dc     = 24'h60;
        for (int i = 0; i < 4; i++)
            push_word({$urandom, $urandom}, i == 3, 2'($urandom_range(0, 3)));
        wait_drain(200);
        end_job();

        // Randomised jobs with source gaps and random backpressure.
        gap_mode = 1;
        for (int j = 0; j < 20; j++) begin
            n = $urandom_range(1, 5);
            case ($urandom_range(0, 2))
                0:       bus.dc = (24'($urandom) & ~24'h60) | 24'h20;
                1:       bus.dc = (24'($urandom) & ~24'h60) | 24'h40;
                default: bus.dc = (24'($urandom) & ~24'h60) | 24'h60;
            endcase
            for (int i = 0; i < n; i++)
                push_word({$urandom, $urandom}, i == n - 1, 2'($urandom_range(0, 3)));
            wait_drain(400);
            end_job();
        end
        gap_mode    = 0;
        force_empty = 0;
        drive_src();

        // Abort after lane 1 of a word, then a fresh job.
        ready_mode = 0;
        bus.dc     = 24'h20;
        push_word(64'hC004_C003_C002_C001, 1'b0, 2'd0);
        push_word(64'hC008_C007_C006_C005, 1'b1, 2'd3);
        n = exp_q.size();
        for (int i = 0; i < 30; i++) begin
            step();
            if (exp_q.size() <= n - 2) break;
        end
        check("abort_point", 64'(exp_q.size()), 64'(n - 2));
        bus.dc          = 24'h0;
        bus.en_in_ready = 1'b0;
        step();
        check("abort_en_valid", 64'(bus.en_in_valid), 64'd0);
        check("abort_de_valid", 64'(bus.de_in_valid), 64'd0);
        exp_q.delete();
        src_q.delete();
        pop_pending = 0;
        drive_src();
        step();
        bus.dc = 24'h20;
        push_word(64'hE004_E003_E002_E001, 1'b1, 2'd3);
        wait_drain(20);
        end_job();

        // Asynchronous reset in the middle of a word.
        bus.dc = 24'h20;
        push_word(64'h8888_7777_6666_5555, 1'b0, 2'd0);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.en_in_valid), 64'd0);
        check("async_rst_data",  64'(bus.en_in_data),  64'd0);
        check("async_rst_last",  64'(bus.en_in_last),  64'd0);
        exp_q.delete();
        src_q.delete();
        pop_pending = 0;
        drive_src();
        step();
        step();
        rst_n = 1'b1;
        push_word(64'hF004_F003_F002_F001, 1'b1, 2'd3);
        wait_drain(20);
        end_job();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
